// File: rtl/multicycle_core.sv
// Multi-cycle RV64/RV32 integer core (add/sub/and/or, addi, ld/sd, beq) on one handshaked memory port.
// Optional macro BRANCH_EXT_EN adds bne/blt/bge; without it those encodings halt the core.
module multicycle_core #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halted
);

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;
  localparam logic [2:0] LS_F3  = (XLEN == 64) ? 3'b011 : 3'b010;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;
  typedef enum logic [1:0] {K_ALU, K_LOAD, K_STORE, K_BRANCH} kind_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_t;

  state_t                 state;
  logic [31:0]            ir;
  logic [XLEN-1:0]        rf [32];
  logic [XLEN-1:0]        a;
  logic [XLEN-1:0]        b;
  logic [XLEN-1:0]        y;
  logic signed [XLEN-1:0] imm;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  logic signed [XLEN-1:0] imm_i;
  logic signed [XLEN-1:0] imm_s;
  logic signed [XLEN-1:0] imm_b;

  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

`ifdef BRANCH_EXT_EN
  function automatic logic br_f3_ok(input logic [2:0] f);
    return (f == 3'b000) || (f == 3'b001) || (f == 3'b100) || (f == 3'b101);
  endfunction

  function automatic logic br_taken(input logic [2:0] f, input logic [XLEN-1:0] x,
                                    input logic [XLEN-1:0] z);
    logic signed [XLEN-1:0] sx;
    logic signed [XLEN-1:0] sz;
    sx = x;
    sz = z;
    case (f)
      3'b000:  return x == z;
      3'b001:  return x != z;
      3'b100:  return sx < sz;
      3'b101:  return sx >= sz;
      default: return 1'b0;
    endcase
  endfunction
`else
  function automatic logic br_f3_ok(input logic [2:0] f);
    return f == 3'b000;
  endfunction

  function automatic logic br_taken(input logic [2:0] f, input logic [XLEN-1:0] x,
                                    input logic [XLEN-1:0] z);
    return (f == 3'b000) && (x == z);
  endfunction
`endif

  function automatic logic [XLEN-1:0] alu(input alu_t op, input logic [XLEN-1:0] x,
                                          input logic [XLEN-1:0] z);
    case (op)
      ALU_ADD: return x + z;
      ALU_SUB: return x - z;
      ALU_AND: return x & z;
      default: return x | z;
    endcase
  endfunction

  logic                   dec_legal;
  kind_t                  dec_kind;
  alu_t                   dec_alu;
  logic                   dec_use_imm;
  logic signed [XLEN-1:0] dec_imm;

  // Decode is a pure function of IR; it is sampled for legality in DECODE and steers EXECUTE/MEM/WB.
  always_comb begin
    dec_legal   = 1'b0;
    dec_kind    = K_ALU;
    dec_alu     = ALU_ADD;
    dec_use_imm = 1'b0;
    dec_imm     = '0;
    case (opcode)
      OPC_R: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'b000:  begin dec_legal = 1'b1; dec_alu = ALU_ADD; end
            3'b110:  begin dec_legal = 1'b1; dec_alu = ALU_OR;  end
            3'b111:  begin dec_legal = 1'b1; dec_alu = ALU_AND; end
            default: dec_legal = 1'b0;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_alu   = ALU_SUB;
        end
      end
      OPC_I: begin
        dec_legal   = (f3 == 3'b000);
        dec_use_imm = 1'b1;
        dec_imm     = imm_i;
      end
      OPC_LD: begin
        dec_legal = (f3 == LS_F3);
        dec_kind  = K_LOAD;
        dec_imm   = imm_i;
      end
      OPC_ST: begin
        dec_legal = (f3 == LS_F3);
        dec_kind  = K_STORE;
        dec_imm   = imm_s;
      end
      OPC_BR: begin
        dec_legal = br_f3_ok(f3);
        dec_kind  = K_BRANCH;
        dec_imm   = imm_b;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] eff_addr;
  logic [XLEN-1:0] alu_b;

  assign pc_plus4  = pc + FOUR;
  assign br_target = pc + $unsigned(imm);
  assign eff_addr  = a + $unsigned(imm);
  assign alu_b     = dec_use_imm ? $unsigned(imm) : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retire    <= 1'b0;
      halted    <= 1'b0;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      y         <= '0;
      imm       <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        // FETCH: after reset the request is raised here; otherwise it was raised on entry.
        FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            ir      <= mem_rdata[31:0];
            state   <= DECODE;
          end
        end
        DECODE: begin
          a   <= (rs1 == 5'd0) ? '0 : rf[rs1];
          b   <= (rs2 == 5'd0) ? '0 : rf[rs2];
          imm <= dec_imm;
          if (dec_legal) begin
            state <= EXECUTE;
          end else begin
            halted <= 1'b1;
            state  <= HALT;
          end
        end
        EXECUTE: begin
          case (dec_kind)
            K_ALU: begin
              y     <= alu(dec_alu, a, alu_b);
              state <= WB;
            end
            K_LOAD, K_STORE: begin
              y         <= eff_addr;
              mem_req   <= 1'b1;
              mem_we    <= (dec_kind == K_STORE);
              mem_addr  <= eff_addr;
              mem_wdata <= b;
              state     <= MEM;
            end
            default: begin
              if (br_taken(f3, a, b)) begin
                pc <= br_target;
                if (br_target[1:0] != 2'b00) begin
                  halted <= 1'b1;
                  state  <= HALT;
                end else begin
                  retire   <= 1'b1;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= br_target;
                  state    <= FETCH;
                end
              end else begin
                pc       <= pc_plus4;
                retire   <= 1'b1;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= pc_plus4;
                state    <= FETCH;
              end
            end
          endcase
        end
        // MEM: a completed store retires straight into the next fetch request.
        MEM: begin
          if (mem_ready) begin
            if (mem_we) begin
              pc       <= pc_plus4;
              retire   <= 1'b1;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc_plus4;
              state    <= FETCH;
            end else begin
              mem_req <= 1'b0;
              y       <= mem_rdata;
              state   <= WB;
            end
          end
        end
        WB: begin
          if (rd != 5'd0) rf[rd] <= y;
          pc       <= pc_plus4;
          retire   <= 1'b1;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc_plus4;
          state    <= FETCH;
        end
        HALT: begin
          mem_req <= 1'b0;
          halted  <= 1'b1;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core (XLEN=64): programs in a behavioural memory, checks results and timing.
module tb_multicycle_core;
  localparam int XLEN = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic [63:0] pc;
  logic        retire;
  logic        halted;

  multicycle_core #(.XLEN(XLEN), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc(pc),
    .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [64];
  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  int          wait_n = 0;
  int          wcnt = 0;
  int          n_ret = 0;
  int          req_start = -1;
  int          ret_cyc[$];
  logic [63:0] ret_pc[$];
  logic [63:0] wr_addr[$];
  logic [63:0] wr_data[$];
  logic        new_req = 1'b1;
  logic        hold_bad = 1'b0;
  logic [63:0] hold_addr;
  logic        hold_we;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    logic [31:0] im;
    im = imm;
    return {im[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2, input logic [4:0] rs1);
    logic [31:0] im;
    im = imm;
    return {im[11:5], rs2, rs1, 3'b011, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    logic [31:0] im;
    im = imm;
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [63:0] rd_word(input logic [63:0] a);
    logic [63:0] w;
    w = mem[a[8:3]];
    return a[2] ? {32'h0, w[63:32]} : w;
  endfunction

  task automatic put_insn(input logic [63:0] a, input logic [31:0] w);
    if (a[2]) mem[a[8:3]][63:32] = w;
    else      mem[a[8:3]][31:0]  = w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 64'h0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    n_ret = 0;
    ret_cyc.delete();
    ret_pc.delete();
    wr_addr.delete();
    wr_data.delete();
    hold_bad  = 1'b0;
    new_req   = 1'b1;
    req_start = -1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_halt(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check_vec({tag, "_halted"}, {63'h0, halted}, 64'd1);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (mem_req === 1'b1 && mem_ready === 1'b1) begin
      wcnt    = 0;
      new_req = 1'b1;
      if (mem_we === 1'b1) begin
        mem[mem_addr[8:3]] = mem_wdata;
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
      end
    end
  end

  always @(negedge clk) begin
    if (retire === 1'b1) begin
      n_ret++;
      ret_cyc.push_back(cyc);
      ret_pc.push_back(pc);
    end
    if (mem_req === 1'b1) begin
      if (req_start < 0) req_start = cyc;
      if (new_req) begin
        hold_addr = mem_addr;
        hold_we   = mem_we;
        new_req   = 1'b0;
      end else if (mem_addr !== hold_addr || mem_we !== hold_we) begin
        hold_bad = 1'b1;
      end
      if (wcnt >= wait_n) begin
        mem_ready = 1'b1;
        mem_rdata = rd_word(mem_addr);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
        wcnt++;
      end
    end else begin
      new_req   = 1'b1;
      mem_ready = 1'b0;
      wcnt      = 0;
    end
  end

  logic [31:0] bad_ins [4];
  logic        bad;

  initial begin
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 64'h0;

    // ALU program, reset values, basic latencies
    clear_mem();
    put_insn(0,  enc_i(5, 0, 3'b000, 1, 7'h13));
    put_insn(4,  enc_i(-3, 0, 3'b000, 2, 7'h13));
    put_insn(8,  enc_r(7'h00, 2, 1, 3'b000, 3));
    put_insn(12, enc_r(7'h20, 2, 1, 3'b000, 4));
    put_insn(16, enc_r(7'h00, 2, 1, 3'b111, 5));
    put_insn(20, enc_r(7'h00, 2, 1, 3'b110, 6));
    put_insn(24, enc_s(256, 3, 0));
    put_insn(28, enc_s(264, 4, 0));
    put_insn(32, enc_s(272, 5, 0));
    put_insn(36, enc_s(280, 6, 0));
    put_insn(40, enc_b(8, 2, 1, 3'b000));
    put_insn(44, enc_i(1, 0, 3'b000, 7, 7'h13));
    put_insn(48, enc_s(288, 7, 0));
    put_insn(52, 32'hFFFF_FFFF);
    #1 rst_n = 1'b0;
    #1;
    check_vec("rst_mem_req", {63'h0, mem_req}, 64'd0);
    check_vec("rst_mem_we", {63'h0, mem_we}, 64'd0);
    check_vec("rst_mem_addr", mem_addr, 64'd0);
    check_vec("rst_mem_wdata", mem_wdata, 64'd0);
    check_vec("rst_pc", pc, 64'd0);
    check_vec("rst_retire", {63'h0, retire}, 64'd0);
    check_vec("rst_halted", {63'h0, halted}, 64'd0);
    wait_n = 0;
    reset_dut();
    run_until_halt("alu", 200);
    check_vec("alu_pc3", ret_pc[2], 64'd12);
    check_vec("alu_12cyc", 64'(ret_cyc[2] - req_start), 64'd12);
    check_vec("alu_addi_lat", 64'(ret_cyc[1] - ret_cyc[0]), 64'd4);
    check_vec("alu_add_lat", 64'(ret_cyc[2] - ret_cyc[1]), 64'd4);
    check_vec("alu_store_lat", 64'(ret_cyc[7] - ret_cyc[6]), 64'd4);
    check_vec("alu_beq_nt_lat", 64'(ret_cyc[10] - ret_cyc[9]), 64'd3);
    check_vec("alu_add", mem[32], 64'd2);
    check_vec("alu_sub", mem[33], 64'd8);
    check_vec("alu_and", mem[34], 64'd5);
    check_vec("alu_or", mem[35], 64'hFFFF_FFFF_FFFF_FFFD);
    check_vec("alu_beq_nt", mem[36], 64'd1);
    check_vec("alu_retires", 64'(n_ret), 64'd13);
    check_vec("alu_halt_pc", pc, 64'd52);

    // Wait states: three stall cycles on every request
    clear_mem();
    put_insn(0,  enc_i(7, 0, 3'b000, 5, 7'h13));
    put_insn(4,  enc_i(1, 5, 3'b000, 5, 7'h13));
    put_insn(8,  enc_s(72, 5, 0));
    put_insn(12, 32'hFFFF_FFFF);
    wait_n = 3;
    reset_dut();
    run_until_halt("wait", 300);
    check_vec("wait_addi_lat", 64'(ret_cyc[1] - ret_cyc[0]), 64'd7);
    check_vec("wait_store_lat", 64'(ret_cyc[2] - ret_cyc[1]), 64'd10);
    check_vec("wait_store_addr", wr_addr[0], 64'd72);
    check_vec("wait_store_val", mem[9], 64'd8);
    check_vec("wait_hold", {63'h0, hold_bad}, 64'd0);

    // Doubleword load/store round trip
    clear_mem();
    mem[4] = 64'hDEAD_BEEF_CAFE_F00D;
    put_insn(0,   enc_b(128, 0, 0, 3'b000));
    put_insn(128, enc_i(32, 0, 3'b011, 1, 7'h03));
    put_insn(132, enc_s(8, 1, 0));
    put_insn(136, enc_i(8, 0, 3'b011, 4, 7'h03));
    put_insn(140, enc_s(16, 4, 0));
    put_insn(144, 32'hFFFF_FFFF);
    wait_n = 0;
    reset_dut();
    run_until_halt("ls", 200);
    check_vec("ls_beq_lat", 64'(ret_cyc[0] - req_start), 64'd3);
    check_vec("ls_beq_pc", ret_pc[0], 64'd128);
    check_vec("ls_load_lat", 64'(ret_cyc[1] - ret_cyc[0]), 64'd5);
    check_vec("ls_store_lat", 64'(ret_cyc[2] - ret_cyc[1]), 64'd4);
    check_vec("ls_load2_lat", 64'(ret_cyc[3] - ret_cyc[2]), 64'd5);
    check_vec("ls_sd_addr", wr_addr[0], 64'd8);
    check_vec("ls_sd_data", wr_data[0], 64'hDEAD_BEEF_CAFE_F00D);
    check_vec("ls_ld_back", mem[2], 64'hDEAD_BEEF_CAFE_F00D);

    // Taken branch, then misaligned target halts
    clear_mem();
    put_insn(0,  enc_i(1, 0, 3'b000, 1, 7'h13));
    put_insn(4,  enc_b(8, 0, 0, 3'b000));
    put_insn(8,  enc_i(2, 0, 3'b000, 1, 7'h13));
    put_insn(12, enc_b(2, 0, 0, 3'b000));
    reset_dut();
    run_until_halt("br", 200);
    check_vec("br_pc", ret_pc[1], 64'd12);
    check_vec("br_lat", 64'(ret_cyc[1] - ret_cyc[0]), 64'd3);
    check_vec("br_retires", 64'(n_ret), 64'd2);
    check_vec("br_halt_pc", pc, 64'd14);
    bad = 1'b0;
    repeat (10) @(negedge clk) if (mem_req !== 1'b0 || retire !== 1'b0) bad = 1'b1;
    check_vec("br_quiet", {63'h0, bad}, 64'd0);

    // Illegal encodings halt at pc 0 without retiring
    bad_ins[0] = 32'hFFFF_FFFF;
    bad_ins[1] = enc_r(7'h01, 2, 1, 3'b000, 3);
    bad_ins[2] = enc_r(7'h20, 2, 1, 3'b111, 3);
    bad_ins[3] = enc_i(0, 0, 3'b010, 1, 7'h03);
    for (int i = 0; i < 4; i++) begin
      clear_mem();
      put_insn(0, bad_ins[i]);
      reset_dut();
      run_until_halt($sformatf("ill%0d", i), 50);
      check_vec($sformatf("ill%0d_pc", i), pc, 64'd0);
      check_vec($sformatf("ill%0d_ret", i), 64'(n_ret), 64'd0);
    end

    // Reset in the middle of a stalled fetch
    clear_mem();
    put_insn(0, enc_i(1, 0, 3'b000, 1, 7'h13));
    put_insn(4, enc_s(40, 1, 0));
    put_insn(8, 32'hFFFF_FFFF);
    wait_n = 3;
    reset_dut();
    begin
      int n;
      n = 0;
      while (n_ret < 1 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check_vec("mid_first_retire", 64'(n_ret), 64'd1);
    @(negedge clk);
    check_vec("mid_req_busy", {63'h0, mem_req}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_vec("mid_req_drop", {63'h0, mem_req}, 64'd0);
    check_vec("mid_pc_rst", pc, 64'd0);
    reset_dut();
    check_vec("mid_pc_rel", pc, 64'd0);
    check_vec("mid_halted_rel", {63'h0, halted}, 64'd0);
    run_until_halt("mid", 300);
    check_vec("mid_store", mem[5], 64'd1);
    check_vec("mid_retires", 64'(n_ret), 64'd2);

    // Signed blt: -1 < 1
    clear_mem();
    put_insn(0,  enc_i(5, 0, 3'b000, 3, 7'h13));
    put_insn(4,  enc_i(1, 0, 3'b000, 1, 7'h13));
    put_insn(8,  enc_i(-1, 0, 3'b000, 2, 7'h13));
    put_insn(12, enc_b(8, 1, 2, 3'b100));
    put_insn(16, enc_i(9, 0, 3'b000, 3, 7'h13));
    put_insn(20, enc_s(48, 3, 0));
    put_insn(24, 32'hFFFF_FFFF);
    wait_n = 0;
    reset_dut();
    run_until_halt("blt", 200);
`ifdef BRANCH_EXT_EN
    check_vec("blt_target", ret_pc[3], 64'd20);
    check_vec("blt_store", mem[6], 64'd5);
    check_vec("blt_halt_pc", pc, 64'd24);
`else
    check_vec("blt_halt_pc", pc, 64'd12);
    check_vec("blt_retires", 64'(n_ret), 64'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
